// File: rtl/vpp_measure_mc.sv
// rtl/vpp_measure_mc.sv - multi-channel windowed max/min/peak-to-peak meter
//
// Tracks per-channel maximum and minimum of ADC samples over a measurement
// window and publishes max, min and max-min for every channel, optionally
// averaged over 2^AVG_LOG2 windows.
//
// Ports:
//   ad_clk     sole clock
//   rst        asynchronous active-high reset
//   enable     measurement enable; low forces IDLE and drops partial work
//   mode       0 = window is one trigger period, 1 = window is win_len samples
//   win_len    samples per window in mode 1 (0 behaves as 1)
//   ad_valid   sample strobe shared by all channels
//   ad_data    packed samples, channel k at [k*DW +: DW]
//   ad_pulse   trigger, asynchronous to ad_clk
//   ad_vpp     packed per-channel peak-to-peak result
//   ad_max     packed per-channel maximum result
//   ad_min     packed per-channel minimum result
//   res_valid  one-cycle strobe coincident with new result values
//   timeout    no trigger edge within TIMEOUT cycles (mode 0)
module vpp_measure_mc #(
    parameter int DW       = 8,
    parameter int CH       = 2,
    parameter int CNT_W    = 16,
    parameter int AVG_LOG2 = 0,
    parameter int TIMEOUT  = 1000000
) (
    input  logic             ad_clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             mode,
    input  logic [CNT_W-1:0] win_len,
    input  logic             ad_valid,
    input  logic [CH*DW-1:0] ad_data,
    input  logic             ad_pulse,
    output logic [CH*DW-1:0] ad_vpp,
    output logic [CH*DW-1:0] ad_max,
    output logic [CH*DW-1:0] ad_min,
    output logic             res_valid,
    output logic             timeout
);

    localparam int ACC_W = DW + AVG_LOG2;
    localparam int AC_W  = AVG_LOG2 + 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [AC_W-1:0]  AVG_LAST = AC_W'((1 << AVG_LOG2) - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               mode_lat_q, mode_lat_d;
    logic               sync1_q, sync1_d;
    logic               sync2_q, sync2_d;
    logic               sync3_q, sync3_d;
    logic               trig_q, trig_d;
    logic [CNT_W-1:0]   win_cnt_q, win_cnt_d;
    logic [CH*DW-1:0]   max_q, max_d;
    logic [CH*DW-1:0]   min_q, min_d;
    logic [CH*ACC_W-1:0] acc_vpp_q, acc_vpp_d;
    logic [CH*ACC_W-1:0] acc_max_q, acc_max_d;
    logic [CH*ACC_W-1:0] acc_min_q, acc_min_d;
    logic [AC_W-1:0]    acc_cnt_q, acc_cnt_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic               timeout_q, timeout_d;
    logic [CH*DW-1:0]   vpp_out_q, vpp_out_d;
    logic [CH*DW-1:0]   max_out_q, max_out_d;
    logic [CH*DW-1:0]   min_out_q, min_out_d;
    logic               res_valid_q, res_valid_d;

    logic               close;
    logic [CH*DW-1:0]   close_max, close_min, close_vpp;
    logic [CH*DW-1:0]   new_max, new_min;
    logic [CH*ACC_W-1:0] sum_vpp, sum_max, sum_min;
    logic [CNT_W-1:0]   len_eff, cnt_inc;

    always_comb begin
        state_d     = state_q;
        mode_lat_d  = mode_lat_q;
        // Two-flop synchroniser, then a delayed copy for edge detection; the
        // edge itself is registered so the FSM sees it 3 cycles after the rise.
        sync1_d     = ad_pulse;
        sync2_d     = sync1_q;
        sync3_d     = sync2_q;
        trig_d      = sync2_q & ~sync3_q;
        win_cnt_d   = win_cnt_q;
        max_d       = max_q;
        min_d       = min_q;
        acc_vpp_d   = acc_vpp_q;
        acc_max_d   = acc_max_q;
        acc_min_d   = acc_min_q;
        acc_cnt_d   = acc_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        timeout_d   = timeout_q;
        vpp_out_d   = vpp_out_q;
        max_out_d   = max_out_q;
        min_out_d   = min_out_q;
        res_valid_d = 1'b0;
        close       = 1'b0;
        close_max   = max_q;
        close_min   = min_q;

        len_eff = (win_len == '0) ? CNT_W'(1) : win_len;
        // Saturating so a long mode-0 window never wraps back to "empty".
        cnt_inc = (&win_cnt_q) ? win_cnt_q : win_cnt_q + CNT_W'(1);

        // Running extrema including the current sample; an empty window seeds.
        for (int k = 0; k < CH; k++) begin
            new_max[k*DW +: DW] = (win_cnt_q == '0 || ad_data[k*DW +: DW] > max_q[k*DW +: DW])
                                  ? ad_data[k*DW +: DW] : max_q[k*DW +: DW];
            new_min[k*DW +: DW] = (win_cnt_q == '0 || ad_data[k*DW +: DW] < min_q[k*DW +: DW])
                                  ? ad_data[k*DW +: DW] : min_q[k*DW +: DW];
        end

        if (state_q == S_IDLE) begin
            mode_lat_d = mode;
        end

        if (!enable) begin
            state_d   = S_IDLE;
            win_cnt_d = '0;
            acc_vpp_d = '0;
            acc_max_d = '0;
            acc_min_d = '0;
            acc_cnt_d = '0;
            timeout_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d   = S_ARM;
                    win_cnt_d = '0;
                end
                S_ARM, S_RUN: begin
                    if (!mode_lat_q) begin
                        if (trig_q) begin
                            // Edge closes the running window; a sample in the
                            // same cycle already belongs to the next one.
                            close   = (state_q == S_RUN) && (win_cnt_q != '0);
                            state_d = S_RUN;
                            if (ad_valid) begin
                                max_d     = ad_data;
                                min_d     = ad_data;
                                win_cnt_d = CNT_W'(1);
                            end else begin
                                win_cnt_d = '0;
                            end
                        end else if (state_q == S_RUN && ad_valid) begin
                            max_d     = new_max;
                            min_d     = new_min;
                            win_cnt_d = cnt_inc;
                        end
                    end else if (ad_valid) begin
                        state_d = S_RUN;
                        if (cnt_inc >= len_eff) begin
                            // Closing sample is part of the window it closes.
                            close     = 1'b1;
                            close_max = new_max;
                            close_min = new_min;
                            win_cnt_d = '0;
                        end else begin
                            max_d     = new_max;
                            min_d     = new_min;
                            win_cnt_d = cnt_inc;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        for (int k = 0; k < CH; k++) begin
            close_vpp[k*DW +: DW]  = close_max[k*DW +: DW] - close_min[k*DW +: DW];
            sum_vpp[k*ACC_W +: ACC_W] = acc_vpp_q[k*ACC_W +: ACC_W] + ACC_W'(close_vpp[k*DW +: DW]);
            sum_max[k*ACC_W +: ACC_W] = acc_max_q[k*ACC_W +: ACC_W] + ACC_W'(close_max[k*DW +: DW]);
            sum_min[k*ACC_W +: ACC_W] = acc_min_q[k*ACC_W +: ACC_W] + ACC_W'(close_min[k*DW +: DW]);
        end

        if (close) begin
            if (acc_cnt_q == AVG_LAST) begin
                for (int k = 0; k < CH; k++) begin
                    vpp_out_d[k*DW +: DW] = sum_vpp[k*ACC_W + AVG_LOG2 +: DW];
                    max_out_d[k*DW +: DW] = sum_max[k*ACC_W + AVG_LOG2 +: DW];
                    min_out_d[k*DW +: DW] = sum_min[k*ACC_W + AVG_LOG2 +: DW];
                end
                res_valid_d = 1'b1;
                timeout_d   = 1'b0;
                acc_vpp_d   = '0;
                acc_max_d   = '0;
                acc_min_d   = '0;
                acc_cnt_d   = '0;
            end else begin
                acc_vpp_d = sum_vpp;
                acc_max_d = sum_max;
                acc_min_d = sum_min;
                acc_cnt_d = acc_cnt_q + AC_W'(1);
            end
        end

        // Trigger watchdog, mode 0 only. Never coincides with a close since
        // a mode-0 close needs a trigger edge, which clears the counter.
        if (enable && !mode_lat_q && state_q != S_IDLE) begin
            if (trig_q) begin
                tmo_cnt_d = '0;
            end else if (tmo_cnt_q == TMO_LAST) begin
                tmo_cnt_d = '0;
                timeout_d = 1'b1;
                state_d   = S_ARM;
                win_cnt_d = '0;
                acc_vpp_d = '0;
                acc_max_d = '0;
                acc_min_d = '0;
                acc_cnt_d = '0;
            end else begin
                tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            end
        end else begin
            tmo_cnt_d = '0;
        end
    end

    always_ff @(posedge ad_clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mode_lat_q  <= 1'b0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            sync3_q     <= 1'b0;
            trig_q      <= 1'b0;
            win_cnt_q   <= '0;
            max_q       <= '0;
            min_q       <= '0;
            acc_vpp_q   <= '0;
            acc_max_q   <= '0;
            acc_min_q   <= '0;
            acc_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
            timeout_q   <= 1'b0;
            vpp_out_q   <= '0;
            max_out_q   <= '0;
            min_out_q   <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_lat_q  <= mode_lat_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            sync3_q     <= sync3_d;
            trig_q      <= trig_d;
            win_cnt_q   <= win_cnt_d;
            max_q       <= max_d;
            min_q       <= min_d;
            acc_vpp_q   <= acc_vpp_d;
            acc_max_q   <= acc_max_d;
            acc_min_q   <= acc_min_d;
            acc_cnt_q   <= acc_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            timeout_q   <= timeout_d;
            vpp_out_q   <= vpp_out_d;
            max_out_q   <= max_out_d;
            min_out_q   <= min_out_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign ad_vpp    = vpp_out_q;
    assign ad_max    = max_out_q;
    assign ad_min    = min_out_q;
    assign res_valid = res_valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_vpp_measure_mc.sv
// tb/tb_vpp_measure_mc.sv - directed self-checking bench for vpp_measure_mc
module tb_vpp_measure_mc;

    logic        ad_clk = 1'b0;
    logic        rst    = 1'b1;

    logic        en_a = 0, mode_a = 0, valid_a = 0, pulse_a = 0;
    logic [15:0] win_len_a = 16'd0, data_a = 16'd0;
    logic [15:0] vpp_a, max_a, min_a;
    logic        rv_a, tmo_a;

    logic        en_b = 0, mode_b = 0, valid_b = 0, pulse_b = 0;
    logic [15:0] win_len_b = 16'd0, data_b = 16'd0;
    logic [15:0] vpp_b, max_b, min_b;
    logic        rv_b, tmo_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 ad_clk = ~ad_clk;

    vpp_measure_mc #(.DW(8), .CH(2), .CNT_W(16), .AVG_LOG2(0), .TIMEOUT(100)) dut_a (
        .ad_clk(ad_clk), .rst(rst), .enable(en_a), .mode(mode_a), .win_len(win_len_a),
        .ad_valid(valid_a), .ad_data(data_a), .ad_pulse(pulse_a),
        .ad_vpp(vpp_a), .ad_max(max_a), .ad_min(min_a), .res_valid(rv_a), .timeout(tmo_a)
    );

    vpp_measure_mc #(.DW(8), .CH(2), .CNT_W(16), .AVG_LOG2(2), .TIMEOUT(100)) dut_b (
        .ad_clk(ad_clk), .rst(rst), .enable(en_b), .mode(mode_b), .win_len(win_len_b),
        .ad_valid(valid_b), .ad_data(data_b), .ad_pulse(pulse_b),
        .ad_vpp(vpp_b), .ad_max(max_b), .ad_min(min_b), .res_valid(rv_b), .timeout(tmo_b)
    );

    task automatic drive_a(input logic p, input logic v, input logic [7:0] d0, input logic [7:0] d1);
        pulse_a = p;
        valid_a = v;
        data_a  = {d1, d0};
        @(posedge ad_clk);
        #1;
    endtask

    // One 64-cycle trigger period on DUT A, pulse high for 8 cycles, ch1 = 77.
    // The sample at c == 3 coincides with the internal trigger edge.
    task automatic run_period(input logic [7:0] base, input int sc1, input logic [7:0] sv1,
                              input int sc2, input logic [7:0] sv2, input logic exp_res,
                              input logic [7:0] emax, input logic [7:0] emin, input string tag);
        logic [7:0] d0;
        logic       exp_rv;
        for (int c = 0; c < 64; c++) begin
            d0 = (c == sc1) ? sv1 : ((c == sc2) ? sv2 : base);
            drive_a(c < 8, 1'b1, d0, 8'd77);
            exp_rv = (c == 3) ? exp_res : 1'b0;
            n_checks++;
            if (rv_a !== exp_rv) begin
                n_fail++;
                $display("FAIL %s res_valid c=%0d got %b expected %b", tag, c, rv_a, exp_rv);
            end
            if (c == 3 && exp_res) begin
                n_checks++;
                if (max_a !== {8'd77, emax}) begin
                    n_fail++;
                    $display("FAIL %s ad_max got %h expected %h", tag, max_a, {8'd77, emax});
                end
                n_checks++;
                if (min_a !== {8'd77, emin}) begin
                    n_fail++;
                    $display("FAIL %s ad_min got %h expected %h", tag, min_a, {8'd77, emin});
                end
                n_checks++;
                if (vpp_a !== {8'd0, 8'(emax - emin)}) begin
                    n_fail++;
                    $display("FAIL %s ad_vpp got %h expected %h", tag, vpp_a, {8'd0, 8'(emax - emin)});
                end
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge ad_clk);
        #1;
        n_checks++;
        if ({vpp_a, max_a, min_a, rv_a, tmo_a} !== 50'd0) begin
            n_fail++;
            $display("FAIL reset_a got vpp=%h max=%h min=%h rv=%b tmo=%b expected all 0",
                     vpp_a, max_a, min_a, rv_a, tmo_a);
        end
        n_checks++;
        if ({vpp_b, max_b, min_b, rv_b, tmo_b} !== 50'd0) begin
            n_fail++;
            $display("FAIL reset_b got vpp=%h max=%h min=%h rv=%b tmo=%b expected all 0",
                     vpp_b, max_b, min_b, rv_b, tmo_b);
        end
        rst = 1'b0;
        drive_a(0, 0, 0, 0);
    endtask

    task automatic test_mode0_period;
        mode_a = 1'b0;
        en_a   = 1'b1;
        drive_a(0, 0, 0, 0);
        run_period(8'd100, 5, 8'd200, 10, 8'd10, 1'b0, 8'd0, 8'd0, "period0");
        for (int p = 1; p < 4; p++) begin
            run_period(8'd100, 5, 8'd200, 10, 8'd10, 1'b1, 8'd200, 8'd10, "period");
        end
    endtask

    task automatic test_timeout;
        // Last internal trigger edge was seen at c == 3 of the previous period.
        for (int c = 64; c <= 110; c++) begin
            drive_a(0, 1, 8'd100, 8'd77);
            n_checks++;
            if (rv_a !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_norv c=%0d got %b expected 0", c, rv_a);
            end
            if (c == 102 || c == 103) begin
                n_checks++;
                if (tmo_a !== (c == 103)) begin
                    n_fail++;
                    $display("FAIL timeout_edge c=%0d got %b expected %b", c, tmo_a, c == 103);
                end
            end
        end
        n_checks++;
        if ({max_a, min_a, vpp_a} !== {8'd77, 8'd200, 8'd77, 8'd10, 8'd0, 8'd190}) begin
            n_fail++;
            $display("FAIL timeout_hold got max=%h min=%h vpp=%h expected 4dc8 4d0a 00be", max_a, min_a, vpp_a);
        end
        run_period(8'd100, 5, 8'd200, 10, 8'd10, 1'b0, 8'd0, 8'd0, "resume_arm");
        n_checks++;
        if (tmo_a !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_still got %b expected 1", tmo_a);
        end
        run_period(8'd100, 5, 8'd200, 10, 8'd10, 1'b1, 8'd200, 8'd10, "resume_res");
        n_checks++;
        if (tmo_a !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_clear got %b expected 0", tmo_a);
        end
    endtask

    task automatic test_coincident;
        run_period(8'd50, -1, 8'd0, -1, 8'd0, 1'b1, 8'd200, 8'd10, "coin_a");
        run_period(8'd50, 3, 8'd255, -1, 8'd0, 1'b1, 8'd50, 8'd50, "coin_b");
        run_period(8'd50, -1, 8'd0, -1, 8'd0, 1'b1, 8'd255, 8'd50, "coin_c");
    endtask

    task automatic test_mode1;
        logic [7:0] s0 [10];
        logic [7:0] s1 [10];
        logic [7:0] w0 [3];
        s0 = '{8'd3, 8'd9, 8'd1, 8'd7, 8'd4, 8'd8, 8'd8, 8'd8, 8'd8, 8'd8};
        s1 = '{8'd100, 8'd101, 8'd102, 8'd103, 8'd104, 8'd20, 8'd20, 8'd20, 8'd20, 8'd20};
        w0 = '{8'd50, 8'd60, 8'd70};
        en_a = 1'b0;
        drive_a(0, 0, 0, 0);
        mode_a    = 1'b1;
        win_len_a = 16'd5;
        en_a      = 1'b1;
        drive_a(0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            drive_a(0, 1, s0[i], s1[i]);
            n_checks++;
            if (rv_a !== (i == 4 || i == 9)) begin
                n_fail++;
                $display("FAIL mode1_rv i=%0d got %b expected %b", i, rv_a, i == 4 || i == 9);
            end
            if (i == 4) begin
                n_checks++;
                if ({max_a, min_a, vpp_a} !== {8'd104, 8'd9, 8'd100, 8'd1, 8'd4, 8'd8}) begin
                    n_fail++;
                    $display("FAIL mode1_w1 got max=%h min=%h vpp=%h expected 6809 6401 0408", max_a, min_a, vpp_a);
                end
            end
            if (i == 9) begin
                n_checks++;
                if ({max_a, min_a, vpp_a} !== {8'd20, 8'd8, 8'd20, 8'd8, 8'd0, 8'd0}) begin
                    n_fail++;
                    $display("FAIL mode1_w2 got max=%h min=%h vpp=%h expected 1408 1408 0000", max_a, min_a, vpp_a);
                end
            end
        end
        win_len_a = 16'd0;
        for (int i = 0; i < 3; i++) begin
            drive_a(0, 1, w0[i], 8'd5);
            n_checks++;
            if ({rv_a, max_a, min_a, vpp_a} !== {1'b1, 8'd5, w0[i], 8'd5, w0[i], 16'd0}) begin
                n_fail++;
                $display("FAIL winlen0 i=%0d got rv=%b max=%h min=%h vpp=%h expected sample %h",
                         i, rv_a, max_a, min_a, vpp_a, w0[i]);
            end
        end
        drive_a(0, 0, 8'd99, 8'd99);
        n_checks++;
        if (rv_a !== 1'b0 || tmo_a !== 1'b0) begin
            n_fail++;
            $display("FAIL mode1_idle got rv=%b tmo=%b expected 0 0", rv_a, tmo_a);
        end
    endtask

    task automatic test_avg;
        logic [7:0] g1 [16];
        logic [7:0] g2 [4];
        g1 = '{8'd5, 8'd15, 8'd10, 8'd10, 8'd5, 8'd25, 8'd10, 8'd10,
               8'd6, 8'd36, 8'd20, 8'd20, 8'd7, 8'd48, 8'd30, 8'd30};
        g2 = '{8'd1, 8'd3, 8'd2, 8'd2};
        en_b = 1'b1; mode_b = 1'b1; win_len_b = 16'd4; valid_b = 1'b0;
        @(posedge ad_clk); #1;
        for (int i = 0; i < 32; i++) begin
            valid_b = 1'b1;
            data_b  = {8'd9, (i < 16) ? g1[i] : g2[i % 4]};
            @(posedge ad_clk); #1;
            n_checks++;
            if (rv_b !== (i == 15 || i == 31)) begin
                n_fail++;
                $display("FAIL avg_rv i=%0d got %b expected %b", i, rv_b, i == 15 || i == 31);
            end
            if (i == 15) begin
                n_checks++;
                if ({max_b, min_b, vpp_b} !== {8'd9, 8'd31, 8'd9, 8'd5, 8'd0, 8'd25}) begin
                    n_fail++;
                    $display("FAIL avg_g1 got max=%h min=%h vpp=%h expected 091f 0905 0019", max_b, min_b, vpp_b);
                end
            end
            if (i == 31) begin
                n_checks++;
                if ({max_b, min_b, vpp_b} !== {8'd9, 8'd3, 8'd9, 8'd1, 8'd0, 8'd2}) begin
                    n_fail++;
                    $display("FAIL avg_g2 got max=%h min=%h vpp=%h expected 0903 0901 0002", max_b, min_b, vpp_b);
                end
            end
        end
        valid_b = 1'b0;
    endtask

    task automatic test_enable_reset;
        en_a = 1'b0;
        drive_a(0, 0, 0, 0);
        mode_a = 1'b0;
        en_a   = 1'b1;
        drive_a(0, 0, 0, 0);
        run_period(8'd100, 5, 8'd200, 10, 8'd10, 1'b0, 8'd0, 8'd0, "en_arm");
        en_a = 1'b0;
        for (int c = 0; c < 64; c++) begin
            drive_a(c < 8, 1, 8'd100, 8'd77);
            n_checks++;
            if (rv_a !== 1'b0) begin
                n_fail++;
                $display("FAIL endrop_rv c=%0d got %b expected 0", c, rv_a);
            end
        end
        n_checks++;
        if ({max_a, min_a, vpp_a} !== {8'd5, 8'd70, 8'd5, 8'd70, 16'd0}) begin
            n_fail++;
            $display("FAIL endrop_hold got max=%h min=%h vpp=%h expected 0546 0546 0000", max_a, min_a, vpp_a);
        end
        en_a = 1'b1;
        drive_a(0, 1, 8'd100, 8'd77);
        run_period(8'd100, 5, 8'd200, 10, 8'd10, 1'b0, 8'd0, 8'd0, "rst_arm");
        for (int c = 0; c < 20; c++) begin
            drive_a(0, 1, 8'd120, 8'd77);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({vpp_a, max_a, min_a, rv_a, tmo_a} !== 50'd0) begin
            n_fail++;
            $display("FAIL midrst_a got vpp=%h max=%h min=%h rv=%b tmo=%b expected all 0",
                     vpp_a, max_a, min_a, rv_a, tmo_a);
        end
        n_checks++;
        if ({vpp_b, max_b, min_b, rv_b} !== 49'd0) begin
            n_fail++;
            $display("FAIL midrst_b got vpp=%h max=%h min=%h rv=%b expected all 0", vpp_b, max_b, min_b, rv_b);
        end
        @(posedge ad_clk); #1;
        n_checks++;
        if (rv_a !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_rv got %b expected 0", rv_a);
        end
        rst  = 1'b0;
        en_a = 1'b0;
    endtask

    initial begin
        test_reset();
        test_mode0_period();
        test_timeout();
        test_coincident();
        test_mode1();
        test_avg();
        test_enable_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vpp_measure_mc.md
Name: vpp_measure_mc

Overview:
Parametrised multi-channel successor of the single-channel peak-to-peak meter in the AD capture path. Tracks per-channel max/min of ADC samples over a measurement window and publishes max, min and Vpp (max-min) for every channel. The window is either one full period of a trigger pulse or a programmable sample count. Results can be averaged over 2^AVG_LOG2 windows. Fed by the ADC front end; results go to the display/UART reporting logic.

Parameters:
DW, 8, sample width per channel (unsigned)
CH, 2, number of channels
CNT_W, 16, width of win_len and sample counter
AVG_LOG2, 0, log2 of windows averaged per published result (0 = no averaging)
TIMEOUT, 1000000, ad_clk cycles without a trigger edge before timeout (mode 0)

Ports:
ad_clk  in  1  sole clock
rst  in  1  asynchronous, active-high reset
enable  in  1  measurement enable
mode  in  1  0 = trigger-period window, 1 = sample-count window
win_len  in  CNT_W  samples per window in mode 1 (0 treated as 1)
ad_valid  in  1  sample strobe for all channels
ad_data  in  CH*DW  packed samples, channel k at [k*DW +: DW]
ad_pulse  in  1  trigger derived from waveform; asynchronous to ad_clk
ad_vpp  out  CH*DW  packed per-channel peak-to-peak
ad_max  out  CH*DW  packed per-channel maximum
ad_min  out  CH*DW  packed per-channel minimum
res_valid  out  1  one-cycle strobe when outputs update
timeout  out  1  no trigger within TIMEOUT cycles

Behaviour:
- Reset: all outputs 0, state IDLE, counters and accumulators cleared, synchroniser flops 0.
- Trigger: ad_pulse passes through a 2-FF synchroniser plus an edge register. trig_edge is the 1-cycle rising edge, 3 cycles after the input rise. Measure every full period, not every other one.
- States:
  - IDLE: outputs hold. mode is latched here only. enable=1 -> ARM.
  - ARM: waits for a window start. Mode 0 starts on trig_edge. Mode 1 starts on the next ad_valid.
  - RUN: accumulates samples. enable=0 from any state -> IDLE next cycle; partial window and averaging group are discarded.
- Window samples:
  - The first ad_valid in the window loads max=min=sample per channel.
  - Each later ad_valid updates max if sample>max, min if sample<min (unsigned compare).
- Window close, mode 0: the next trig_edge closes the window. An ad_valid in the same cycle as trig_edge belongs to the NEW window and seeds it.
- Window close, mode 1: the sample that brings the count to win_len is included in the closing window. The next ad_valid seeds the next window; there is no gap.
- Empty window (closed with 0 samples): nothing is published, the averaging count is unchanged, and the next window starts.
- Closing with AVG_LOG2=0: per-channel outputs register max-min, max, min. res_valid pulses the cycle after close, coincident with the new output values.
- Closing with AVG_LOG2>0:
  - Per-channel accumulators of width DW+AVG_LOG2 sum vpp, max and min.
  - After 2^AVG_LOG2 windows, outputs = sum >> AVG_LOG2 (truncate) and res_valid pulses; the accumulators are then cleared.
  - A close in the same cycle as the final accumulate is handled: the new window's values start a fresh sum.
- Vpp cannot underflow (max>=min by construction). Output width is DW.
- Timeout:
  - Mode 0 only. A cycle counter is cleared on trig_edge and runs in ARM/RUN.
  - On reaching TIMEOUT: timeout=1, go to ARM, and discard the partial window and averaging group. Outputs hold their last values.
  - timeout stays high until the next res_valid or until enable=0.
- Mode 1 never asserts timeout.
- Reset mid-window: immediate clear to reset state, with no res_valid.
- Latency: the trigger rise reaches res_valid in 4 ad_clk cycles (3 sync/edge + 1 output register).

Test Plan:
- CH=2, mode 0, AVG_LOG2=0. Ch0 ramps 10..200, ch1 constant 77, ad_valid=1, ad_pulse every 64 cycles -> after each period ch0 max=200 min=10 vpp=190, ch1 max=min=77 vpp=0; res_valid once per period, 4 cycles after each pulse rise after the first.
- Mode 1, win_len=5, ch0 samples 3,9,1,7,4 | 8,8,... -> result max=9 min=1 vpp=8 on the 5th sample; the 6th sample (8) seeds the next window; win_len=0 gives a result every sample with vpp=0.
- AVG_LOG2=2, mode 1, win_len=4, four windows with vpp 10,20,30,41 -> a single res_valid with vpp=25 (101>>2); no strobe on the first three windows.
- Mode 0, TIMEOUT=100, pulse stops mid-window -> timeout=1 at cycle 100 after the last edge, outputs unchanged; pulse resumes -> next res_valid clears timeout.
- ad_valid coincident with trig_edge, sample 255 while the prior window max was 50 -> published max=50; the next window's max>=255.
- enable dropped mid-window, then rst asserted mid-window -> no res_valid; after rst all outputs 0, state IDLE.
